// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// BEQ/BNE, sticky illegal trap, retired-instruction counter; stalls on mem_ready.
module control_multicycle #(
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 32,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_control,
    output logic [1:0]             imm_src,
    output logic                   reg_write,
    output logic                   illegal,
    output logic [CNT_WIDTH-1:0]   instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       ready;
    logic [1:0] alu_op;
    logic [2:0] fd_alu;
    logic       fd_ok;
    logic       retire;
    logic       pc_write_i, mem_write_i, ir_write_i, reg_write_i;
    logic       unused_instr_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign unused_instr_bits = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

    // With waiting disabled, every memory access completes in its first cycle.
    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        fd_alu = 3'b000;
        fd_ok  = 1'b1;
        case (funct3)
            3'b000:  fd_alu = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  fd_alu = 3'b101;
            3'b110:  fd_alu = 3'b011;
            3'b111:  fd_alu = 3'b010;
            default: fd_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b01:   alu_control = 3'b001;
            2'b10:   alu_control = fd_alu;
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        pc_write_i  = 1'b0;
        mem_write_i = 1'b0;
        ir_write_i  = 1'b0;
        reg_write_i = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_i = ready;
                pc_write_i = ready;
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = fd_ok ? S_EXECR : S_TRAP;
                    OP_I:         state_nxt = fd_ok ? S_EXECI : S_TRAP;
                    OP_BR:        state_nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_i = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_i = 1'b1;
                if (ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_i = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                // Only BEQ/BNE reach here, so funct3[0] alone picks the sense.
                pc_write_i = funct3[0] ? !zero : zero;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_i = 1'b1;
                state_nxt  = S_ALUWB;
            end
            default: state_nxt = S_TRAP;
        endcase
    end

    assign pc_write  = pc_write_i  & rst_n;
    assign mem_write = mem_write_i & rst_n;
    assign ir_write  = ir_write_i  & rst_n;
    assign reg_write = reg_write_i & rst_n;
    assign illegal   = (state == S_TRAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule
